// File: rtl/mau_wb_bridge.sv
// L1D-side memory access bridge: runs one cache request (refill, uncached read,
// write-through store) as serial Wishbone-classic single-word cycles and acks it.
module mau_wb_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_SIZE  = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mau_req_val,
  input  logic                    mau_req_nc,
  input  logic                    mau_req_we,
  input  logic [ADDR_WIDTH-1:0]   mau_req_addr,
  input  logic [DATA_WIDTH-1:0]   mau_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] mau_req_be,
  output logic                    mau_req_ack,
  output logic                    mau_ack_nc,
  output logic                    mau_ack_we,
  output logic [LINE_SIZE-1:0]    mau_ack_data,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic                    wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i
);

  localparam int BEATS = LINE_SIZE / DATA_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int OFFS  = $clog2(LINE_SIZE / 8);

  typedef enum logic [2:0] {IDLE, WRITE, RDNC, REFILL, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_be;
  logic                  r_nc;
  logic                  r_we;
  logic [BW-1:0]         r_beat;
  logic [LINE_SIZE-1:0]  r_data;

  logic [1:0]            w_sh;
  logic [4:0]            w_bsh;
  logic [SW-1:0]         w_sel;
  logic [DATA_WIDTH-1:0] w_wdat;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [ADDR_WIDTH-1:0] w_word_adr;
  logic [ADDR_WIDTH-1:0] w_line_adr;
  logic                  w_last;
  logic                  w_accept;

  // Sub-word requests arrive LSB-justified; move them onto their bus lanes.
  assign w_sh       = r_addr[1:0];
  assign w_bsh      = {w_sh, 3'b000};
  assign w_sel      = r_be << w_sh;
  assign w_wdat     = r_wdata << w_bsh;
  assign w_rd_word  = wb_dat_i >> w_bsh;
  assign w_word_adr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign w_line_adr = {r_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}} + (ADDR_WIDTH'(r_beat) << 2);
  assign w_last     = (r_beat == BW'(BEATS - 1));
  assign w_accept   = (r_state == IDLE) && mau_req_val;

  assign mau_ack_data = r_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    mau_req_ack = 1'b0;
    mau_ack_nc  = 1'b0;
    mau_ack_we  = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = '0;
    wb_dat_o    = '0;
    wb_sel_o    = '0;
    case (r_state)
      IDLE: begin
        if (mau_req_val) begin
          if (mau_req_we)      w_next = WRITE;
          else if (mau_req_nc) w_next = RDNC;
          else                 w_next = REFILL;
        end
      end
      WRITE: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = 1'b1;
        wb_adr_o = w_word_adr;
        wb_sel_o = w_sel;
        wb_dat_o = w_wdat;
        if (wb_ack_i) w_next = RESP;
      end
      RDNC: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = w_word_adr;
        wb_sel_o = w_sel;
        if (wb_ack_i) w_next = RESP;
      end
      REFILL: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_adr_o = w_line_adr;
        wb_sel_o = '1;
        if (wb_ack_i && w_last) w_next = RESP;
      end
      RESP: begin
        mau_req_ack = 1'b1;
        mau_ack_nc  = r_nc;
        mau_ack_we  = r_we;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= mau_req_addr;
      r_wdata <= mau_req_wdata;
      r_be    <= mau_req_be;
      r_nc    <= mau_req_nc;
      r_we    <= mau_req_we;
    end
  end

  // Line assembly; wb_ack_i only matters while a bus cycle is actually open.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (mau_req_val) begin
            r_beat <= '0;
            if (mau_req_we) r_data <= '0;
          end
        end
        RDNC: begin
          if (wb_ack_i) r_data <= {w_rd_word, {(LINE_SIZE-DATA_WIDTH){1'b0}}};
        end
        REFILL: begin
          if (wb_ack_i) begin
            r_data[r_beat*DATA_WIDTH +: DATA_WIDTH] <= wb_dat_i;
            r_beat <= r_beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mau_wb_bridge.sv
// Directed plus randomized bench for mau_wb_bridge with an in-bench Wishbone slave
// and a spec-level model of addresses, lane placement and assembled response data.
module tb_mau_wb_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mau_req_val, mau_req_nc, mau_req_we;
  logic [31:0]  mau_req_addr, mau_req_wdata;
  logic [3:0]   mau_req_be;
  logic         mau_req_ack, mau_ack_nc, mau_ack_we;
  logic [127:0] mau_ack_data;
  logic         wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]  wb_adr_o, wb_dat_o;
  logic [3:0]   wb_sel_o;
  logic         wb_ack_i;
  logic [31:0]  wb_dat_i;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] slv_words [4];

  mau_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .mau_req_val(mau_req_val), .mau_req_nc(mau_req_nc), .mau_req_we(mau_req_we),
    .mau_req_addr(mau_req_addr), .mau_req_wdata(mau_req_wdata), .mau_req_be(mau_req_be),
    .mau_req_ack(mau_req_ack), .mau_ack_nc(mau_ack_nc), .mau_ack_we(mau_ack_we),
    .mau_ack_data(mau_ack_data),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".cyc"}, 128'(wb_cyc_o), 128'(0));
    chk({tag, ".stb"}, 128'(wb_stb_o), 128'(0));
    chk({tag, ".ack"}, 128'(mau_req_ack), 128'(0));
  endtask

  // Issue one request at the current negedge and play the slave; returns at the
  // negedge of the cycle where mau_req_ack is expected.
  task automatic do_req(input bit nc, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int waits, input bit keep_val);
    int          beats;
    logic [1:0]  sh;
    logic [7:0]  sel_full;
    logic [63:0] dat_full;
    logic [31:0] exp_adr, exp_dat;
    logic [3:0]  exp_sel;
    logic [127:0] exp_line;
    sh       = addr[1:0];
    beats    = (we || nc) ? 1 : 4;
    sel_full = {4'b0, be} << sh;
    dat_full = {32'b0, wdata} << (8 * sh);
    exp_dat  = dat_full[31:0];
    mau_req_val   = 1'b1;
    mau_req_nc    = nc;
    mau_req_we    = we;
    mau_req_addr  = addr;
    mau_req_wdata = wdata;
    mau_req_be    = be;
    step();
    for (int b = 0; b < beats; b++) begin
      exp_adr = (we || nc) ? (addr & 32'hFFFF_FFFC) : ((addr & 32'hFFFF_FFF0) + 32'(4 * b));
      exp_sel = (we || nc) ? sel_full[3:0] : 4'hF;
      for (int w = 0; w < waits; w++) begin
        wb_ack_i = 1'b0;
        chk("wait.cyc", 128'(wb_cyc_o), 128'(1));
        chk("wait.adr", 128'(wb_adr_o), 128'(exp_adr));
        chk("wait.ack", 128'(mau_req_ack), 128'(0));
        step();
      end
      wb_ack_i = 1'b1;
      wb_dat_i = slv_words[b];
      chk("beat.cyc", 128'(wb_cyc_o), 128'(1));
      chk("beat.stb", 128'(wb_stb_o), 128'(1));
      chk("beat.we",  128'(wb_we_o),  128'(we));
      chk("beat.adr", 128'(wb_adr_o), 128'(exp_adr));
      chk("beat.sel", 128'(wb_sel_o), 128'(exp_sel));
      if (we) chk("beat.dat", 128'(wb_dat_o), 128'(exp_dat));
      chk("beat.ack", 128'(mau_req_ack), 128'(0));
      step();
      wb_ack_i = 1'b0;
      wb_dat_i = $urandom;
    end
    if (nc) exp_line = {slv_words[0] >> (8 * sh), 96'b0};
    else    exp_line = {slv_words[3], slv_words[2], slv_words[1], slv_words[0]};
    chk("resp.ack", 128'(mau_req_ack), 128'(1));
    chk("resp.nc",  128'(mau_ack_nc),  128'(nc));
    chk("resp.we",  128'(mau_ack_we),  128'(we));
    chk("resp.cyc", 128'(wb_cyc_o),    128'(0));
    if (!we) chk("resp.data", mau_ack_data, exp_line);
    if (!keep_val) mau_req_val = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    int          kind;
    rst_n = 1'b0;
    mau_req_val = 0; mau_req_nc = 0; mau_req_we = 0;
    mau_req_addr = 0; mau_req_wdata = 0; mau_req_be = 0;
    wb_ack_i = 0; wb_dat_i = 0;
    @(negedge clk);
    step();
    step();
    chk_quiet("reset");
    chk("reset.data", mau_ack_data, 128'(0));
    chk("reset.adr",  128'(wb_adr_o), 128'(0));
    rst_n = 1'b1;

    // Stray slave ack while idle must be ignored.
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk_quiet("stray");

    // Directed refill, byte store, uncached halfword read.
    slv_words = '{32'h11, 32'h22, 32'h33, 32'h44};
    do_req(0, 0, 32'h0000_0100, 32'h0, 4'h0, 0, 0);
    chk("refill.line", mau_ack_data, 128'h00000044_00000033_00000022_00000011);
    step();
    chk_quiet("post_refill");
    do_req(0, 1, 32'h0000_0203, 32'h0000_00AB, 4'b0001, 0, 0);
    step();
    slv_words[0] = 32'hBEEF_1234;
    do_req(1, 0, 32'h0000_0402, 32'h0, 4'b0011, 0, 0);
    chk("nc.hw", mau_ack_data, {32'h0000_BEEF, 96'b0});
    step();

    // Refill with two wait cycles before every beat.
    slv_words = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003, 32'hD3D3_0004};
    do_req(0, 0, 32'h0000_1230, 32'h0, 4'h0, 2, 0);
    step();

    // Back-to-back: request held through RESP is not re-accepted.
    slv_words = '{32'h5, 32'h6, 32'h7, 32'h8};
    do_req(0, 0, 32'h0000_0500, 32'h0, 4'h0, 0, 1);
    step();
    chk_quiet("b2b.gap");
    do_req(0, 1, 32'h0000_0600, 32'hCAFE_F00D, 4'hF, 0, 0);
    step();
    chk_quiet("b2b.after");

    // Reset after beat 1 of a refill, then a clean refill.
    mau_req_val = 1; mau_req_nc = 0; mau_req_we = 0; mau_req_addr = 32'h0000_0700;
    step();
    wb_ack_i = 1; wb_dat_i = 32'h1111_1111;
    step();
    wb_dat_i = 32'h2222_2222;
    step();
    rst_n = 1'b0;
    wb_dat_i = 32'h3333_3333;
    step();
    chk_quiet("rst_mid");
    chk("rst_mid.data", mau_ack_data, 128'(0));
    rst_n = 1'b1; wb_ack_i = 0; mau_req_val = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("rst_after");
    end
    slv_words = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003};
    do_req(0, 0, 32'h0000_0700, 32'h0, 4'h0, 1, 0);
    step();

    // Randomized mix of legal requests and wait states.
    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      for (int i = 0; i < 4; i++) slv_words[i] = $urandom;
      case ($urandom_range(0, 2))
        0:       be = 4'b0001;
        1:       begin be = 4'b0011; a[0] = 1'b0; end
        default: begin be = 4'b1111; a[1:0] = 2'b00; end
      endcase
      if (kind == 0) a[3:0] = 4'h0;
      do_req(kind == 2, kind == 1, a, $urandom, be, $urandom_range(0, 2), 0);
      step();
      chk_quiet("rnd.gap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
